// File: rtl/mesh_term_pkg.sv
// Shared definitions for the mesh terminal receiver.
// Field layout, FSM state type and destination matching.
package mesh_term_pkg;

    // Field widths, offsets counted from the packet MSB
    localparam int NJ_W    = 8;
    localparam int ROW_W   = 4;
    localparam int COL_W   = 4;
    localparam int DST_W   = ROW_W + COL_W;
    localparam int DST_OFS = NJ_W;
    localparam int MODE_OFS = NJ_W + DST_W;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        CHECK
    } term_st_e;

    // pkt is the {row,col} destination field of a packet
    function automatic logic dest_match(
        input logic [DST_W-1:0] pkt,
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col,
        input logic [DST_W-1:0] bdcst
    );
        return (pkt == {row, col}) || (pkt == bdcst);
    endfunction

endpackage

// File: rtl/mesh_term_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Head reads as zero while empty so the output is clean after reset.
module mesh_term_fifo #(
    parameter int width = 40,
    parameter int depth = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [width-1:0]           wdata,
    input  logic                       pop,
    output logic [width-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(depth):0]     count
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [width-1:0] r_mem [depth];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;
    logic             w_wr;
    logic             w_rd;

    assign full  = (r_cnt == CW'(depth));
    assign empty = (r_cnt == '0);
    assign count = r_cnt;
    assign w_wr  = push && !full;
    assign w_rd  = pop && !empty;
    assign rdata = empty ? '0 : r_mem[r_rptr];

    // Storage write, no reset needed on the data array
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_wr && !w_rd) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (w_rd && !w_wr) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Writer must never push into a full FIFO
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(push && full))
                else $error("mesh_term_fifo: push while full");
        end
    end

endmodule

// File: rtl/mesh_term_rx.sv
// Terminal receiver for one mesh-router output port.
// Drains, checks destination, buffers accepted packets, counts errors.
module mesh_term_rx
    import mesh_term_pkg::*;
#(
    parameter int         pckg_sz    = 40,
    parameter int         fifo_depth = 8,
    parameter logic [3:0] MY_ROW     = 4'd0,
    parameter logic [3:0] MY_COL     = 4'd0,
    parameter logic [7:0] bdcst      = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pndng,
    input  logic [pckg_sz-1:0] data_in,
    output logic               pop,
    input  logic               rd_en,
    output logic [pckg_sz-1:0] rd_data,
    output logic               rd_vld,
    output logic [15:0]        pkt_cnt,
    output logic [15:0]        err_cnt,
    output logic               err_flag,
    output logic [pckg_sz-1:0] err_pkt,
    input  logic               clr_err
);

    localparam int CW = $clog2(fifo_depth) + 1;

    term_st_e           r_state;
    logic               r_pop;
    logic [pckg_sz-1:0] r_cap;
    logic [15:0]        r_pkt_cnt;
    logic [15:0]        r_err_cnt;
    logic               r_err_flag;
    logic [pckg_sz-1:0] r_err_pkt;

    logic [CW-1:0]      w_count;
    logic [CW-1:0]      w_cnt_nxt;
    logic               w_full;
    logic               w_empty;
    logic               w_match;
    logic               w_push;
    logic               w_miss;
    logic               w_rd_ok;
    logic               w_room;

    assign w_match = dest_match(r_cap[pckg_sz-1-DST_OFS -: DST_W],
                                MY_ROW, MY_COL, bdcst);
    assign w_push    = (r_state == CHECK) && w_match;
    assign w_miss    = (r_state == CHECK) && !w_match;
    assign w_rd_ok   = rd_en && !w_empty;
    assign w_cnt_nxt = w_count + CW'(w_push) - CW'(w_rd_ok);
    assign w_room    = (w_cnt_nxt < CW'(fifo_depth));

    assign pop      = r_pop;
    assign rd_vld   = !w_empty;
    assign pkt_cnt  = r_pkt_cnt;
    assign err_cnt  = r_err_cnt;
    assign err_flag = r_err_flag;
    assign err_pkt  = r_err_pkt;

    mesh_term_fifo #(
        .width (pckg_sz),
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .wdata (r_cap),
        .pop   (rd_en),
        .rdata (rd_data),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Drain FSM; pop is registered and high only in CAPTURE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_pop   <= 1'b0;
            r_cap   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pndng && !w_full) begin
                        r_state <= CAPTURE;
                        r_pop   <= 1'b1;
                    end
                end
                CAPTURE: begin
                    r_cap   <= data_in;
                    r_state <= CHECK;
                    r_pop   <= 1'b0;
                end
                CHECK: begin
                    if (pndng && w_room) begin
                        r_state <= CAPTURE;
                        r_pop   <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_pop   <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of accepted packets
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_cnt <= '0;
        end else if (w_push && (r_pkt_cnt != 16'hFFFF)) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    // Misroute tracking; a new misroute wins over clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
            r_err_pkt  <= '0;
        end else if (w_miss) begin
            r_err_flag <= 1'b1;
            r_err_pkt  <= r_cap;
            if (clr_err) begin
                r_err_cnt <= 16'd1;
            end else if (r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end else if (clr_err) begin
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
            r_err_pkt  <= '0;
        end
    end

endmodule

// File: tb/tb_mesh_term_rx.sv
// Directed bench for mesh_term_rx at terminal (1,2).
// Router source modelled as a packet queue popped on pop edges.
module tb_mesh_term_rx;

    localparam int W = 40;

    logic         clk = 1'b0;
    logic         reset;
    logic         pndng;
    logic [W-1:0] data_in;
    logic         pop;
    logic         rd_en;
    logic [W-1:0] rd_data;
    logic         rd_vld;
    logic [15:0]  pkt_cnt;
    logic [15:0]  err_cnt;
    logic         err_flag;
    logic [W-1:0] err_pkt;
    logic         clr_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int npops = 0;

    logic [W-1:0] src[$];
    int           pop_cyc[$];
    logic [W-1:0] last_rd;
    logic         got_rd;

    mesh_term_rx #(
        .pckg_sz    (W),
        .fifo_depth (8),
        .MY_ROW     (4'd1),
        .MY_COL     (4'd2),
        .bdcst      (8'hFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .data_in  (data_in),
        .pop      (pop),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_vld   (rd_vld),
        .pkt_cnt  (pkt_cnt),
        .err_cnt  (err_cnt),
        .err_flag (err_flag),
        .err_pkt  (err_pkt),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(
        input logic [3:0] r,
        input logic [3:0] c,
        input int         pl
    );
        logic [22:0] p;
        p = pl[22:0];
        return {8'h00, r, c, 1'b0, p};
    endfunction

    task automatic drive_src();
        if (src.size() > 0) begin
            pndng   = 1'b1;
            data_in = src[0];
        end else begin
            pndng   = 1'b0;
            data_in = '0;
        end
    endtask

    task automatic step(input logic rd, input logic clr);
        logic p;
        @(negedge clk);
        rd_en   = rd;
        clr_err = clr;
        p       = pop;
        got_rd  = rd && rd_vld;
        last_rd = rd_data;
        @(posedge clk);
        #1;
        cyc++;
        if (p) begin
            npops++;
            pop_cyc.push_back(cyc);
            if (src.size() > 0) src.delete(0);
        end
        rd_en   = 1'b0;
        clr_err = 1'b0;
        drive_src();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        pndng   = 1'b0;
        data_in = '0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (pop !== 1'b0) begin bad++; $display("FAIL reset_pop got=%b want=0", pop); end
        total++; if (rd_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", rd_vld); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", rd_data); end
        total++; if (pkt_cnt !== 16'd0) begin bad++; $display("FAIL reset_pkt got=%0d want=0", pkt_cnt); end
        total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", err_cnt); end
        total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL reset_flag got=%b want=0", err_flag); end
        total++; if (err_pkt !== '0) begin bad++; $display("FAIL reset_epkt got=%h want=0", err_pkt); end
        @(negedge clk);
        reset = 1'b0;
        step(0, 0);
        total++; if (pop !== 1'b0) begin bad++; $display("FAIL idle_pop got=%b want=0", pop); end
    endtask

    task automatic test_single();
        logic [W-1:0] a;
        int n0;
        a  = mk(4'd1, 4'd2, 23'h12345);
        n0 = npops;
        src.push_back(a);
        drive_src();
        step(0, 0);
        total++; if (pop !== 1'b1) begin bad++; $display("FAIL single_pop1 got=%b want=1", pop); end
        step(0, 0);
        total++; if (pop !== 1'b0) begin bad++; $display("FAIL single_pop2 got=%b want=0", pop); end
        total++; if (rd_vld !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", rd_vld); end
        step(0, 0);
        total++; if (rd_vld !== 1'b1) begin bad++; $display("FAIL single_vld got=%b want=1", rd_vld); end
        total++; if (rd_data !== a) begin bad++; $display("FAIL single_data got=%h want=%h", rd_data, a); end
        total++; if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", pkt_cnt); end
        repeat (2) step(0, 0);
        total++; if (npops - n0 !== 1) begin bad++; $display("FAIL single_npop got=%0d want=1", npops - n0); end
        step(1, 0);
        total++; if (!got_rd || last_rd !== a) begin bad++; $display("FAIL single_read got=%h want=%h", last_rd, a); end
        total++; if (rd_vld !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", rd_vld); end
    endtask

    task automatic test_misroute();
        logic [W-1:0] b;
        int n0;
        b  = mk(4'd3, 4'd3, 23'h0BEEF);
        n0 = npops;
        src.push_back(b);
        drive_src();
        repeat (4) step(0, 0);
        total++; if (npops - n0 !== 1) begin bad++; $display("FAIL mis_npop got=%0d want=1", npops - n0); end
        total++; if (err_flag !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b want=1", err_flag); end
        total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL mis_cnt got=%0d want=1", err_cnt); end
        total++; if (err_pkt !== b) begin bad++; $display("FAIL mis_pkt got=%h want=%h", err_pkt, b); end
        total++; if (rd_vld !== 1'b0) begin bad++; $display("FAIL mis_vld got=%b want=0", rd_vld); end
        total++; if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL mis_pktcnt got=%0d want=1", pkt_cnt); end
        step(0, 1);
        total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL clr_flag got=%b want=0", err_flag); end
        total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL clr_cnt got=%0d want=0", err_cnt); end
        total++; if (err_pkt !== '0) begin bad++; $display("FAIL clr_pkt got=%h want=0", err_pkt); end
    endtask

    task automatic test_bcast();
        logic [W-1:0] c;
        c = mk(4'hF, 4'hF, 23'h00777);
        src.push_back(c);
        drive_src();
        repeat (3) step(0, 0);
        total++; if (pkt_cnt !== 16'd2) begin bad++; $display("FAIL bc_cnt got=%0d want=2", pkt_cnt); end
        total++; if (rd_data !== c) begin bad++; $display("FAIL bc_data got=%h want=%h", rd_data, c); end
        total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL bc_flag got=%b want=0", err_flag); end
        step(1, 0);
    endtask

    task automatic test_clr_collision();
        logic [W-1:0] d;
        logic [W-1:0] e;
        d = mk(4'd0, 4'd0, 23'h00D00);
        e = mk(4'd1, 4'd3, 23'h00E00);
        src.push_back(d);
        drive_src();
        repeat (4) step(0, 0);
        total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL col_pre got=%0d want=1", err_cnt); end
        src.push_back(e);
        drive_src();
        step(0, 0);
        step(0, 0);
        step(0, 1);
        total++; if (err_flag !== 1'b1) begin bad++; $display("FAIL col_flag got=%b want=1", err_flag); end
        total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL col_cnt got=%0d want=1", err_cnt); end
        total++; if (err_pkt !== e) begin bad++; $display("FAIL col_pkt got=%h want=%h", err_pkt, e); end
        step(0, 1);
    endtask

    task automatic test_stream();
        logic [W-1:0] exp[10];
        int  n0;
        int  idx;
        logic ok;
        for (int i = 0; i < 10; i++) begin
            exp[i] = mk(4'd1, 4'd2, 100 + i);
            src.push_back(exp[i]);
        end
        drive_src();
        pop_cyc.delete();
        n0 = npops;
        repeat (30) step(0, 0);
        total++; if (npops - n0 !== 8) begin bad++; $display("FAIL st_pops got=%0d want=8", npops - n0); end
        ok = (pop_cyc.size() == 8);
        for (int i = 1; i < pop_cyc.size(); i++) begin
            if (pop_cyc[i] - pop_cyc[i-1] != 2) ok = 1'b0;
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL st_space got=%b want=1", ok); end
        total++; if (pop !== 1'b0) begin bad++; $display("FAIL st_hold got=%b want=0", pop); end
        step(1, 0);
        total++; if (last_rd !== exp[0]) begin bad++; $display("FAIL st_head got=%h want=%h", last_rd, exp[0]); end
        repeat (6) step(0, 0);
        total++; if (npops - n0 !== 9) begin bad++; $display("FAIL st_one got=%0d want=9", npops - n0); end
        idx = 1;
        repeat (40) begin
            step(1, 0);
            if (got_rd) begin
                total++;
                if (idx > 9 || last_rd !== exp[idx]) begin
                    bad++;
                    $display("FAIL st_order idx=%0d got=%h", idx, last_rd);
                end
                idx++;
            end
        end
        total++; if (idx !== 10) begin bad++; $display("FAIL st_reads got=%0d want=10", idx); end
        total++; if (pkt_cnt !== 16'd12) begin bad++; $display("FAIL st_cnt got=%0d want=12", pkt_cnt); end
    endtask

    task automatic test_rd_every_cycle();
        logic [W-1:0] exp[5];
        int  idx;
        logic ok;
        for (int i = 0; i < 5; i++) begin
            exp[i] = mk(4'd1, 4'd2, 200 + i);
            src.push_back(exp[i]);
        end
        drive_src();
        idx = 0;
        ok  = 1'b1;
        repeat (20) begin
            step(1, 0);
            if (dut.w_count > 4'd1) ok = 1'b0;
            if (got_rd) begin
                if (idx > 4 || last_rd !== exp[idx]) ok = 1'b0;
                idx++;
            end
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rd_occ got=%b want=1", ok); end
        total++; if (idx !== 5) begin bad++; $display("FAIL rd_reads got=%0d want=5", idx); end
        repeat (3) step(1, 0);
        total++; if (got_rd !== 1'b0) begin bad++; $display("FAIL rd_empty got=%b want=0", got_rd); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL rd_edata got=%h want=0", rd_data); end
        total++; if (pkt_cnt !== 16'd17) begin bad++; $display("FAIL rd_cnt got=%0d want=17", pkt_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] f;
        int n0;
        f = mk(4'd1, 4'd2, 23'h0F0F0);
        src.push_back(f);
        drive_src();
        step(0, 0);
        total++; if (pop !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b want=1", pop); end
        reset = 1'b1;
        #1;
        total++; if (pop !== 1'b0) begin bad++; $display("FAIL rm_pop got=%b want=0", pop); end
        total++; if (pkt_cnt !== 16'd0) begin bad++; $display("FAIL rm_cnt got=%0d want=0", pkt_cnt); end
        total++; if (rd_vld !== 1'b0) begin bad++; $display("FAIL rm_vld got=%b want=0", rd_vld); end
        total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL rm_flag got=%b want=0", err_flag); end
        @(negedge clk);
        reset = 1'b0;
        n0 = npops;
        repeat (5) step(0, 0);
        total++; if (npops - n0 !== 1) begin bad++; $display("FAIL rm_npop got=%0d want=1", npops - n0); end
        total++; if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL rm_resume got=%0d want=1", pkt_cnt); end
        total++; if (rd_data !== f) begin bad++; $display("FAIL rm_data got=%h want=%h", rd_data, f); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_misroute();
        test_bcast();
        test_clr_collision();
        test_stream();
        test_rd_every_cycle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
